// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch/sequencing controller for the program counter's branch/advance port.
// Each instruction walks FETCH -> WAIT_MEM -> ISSUE -> SETUP -> PULSE -> HOLD
// and returns to FETCH. A HALT opcode parks the controller until reset.
// bra_result/bra_valid are held steady for one full clock before the inc_pc
// rising edge and one full clock after its falling edge, so the PC register
// (clocked by inc_pc) always samples a settled branch request.
//
// Configuration macro:
//   BRA_RELATIVE_EN  defined   -> taken target = pc + 1 + signed offset field
//                    undefined -> taken target = instr[ADDRESS_WIDTH-1:0]
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high (shared with the PC register)
//   start        in   leave IDLE and begin fetching (level, IDLE only)
//   pc           in   current PC value
//   mem_addr     out  instruction memory read address (held until next fetch)
//   mem_rd       out  one-cycle read strobe
//   mem_rdata    in   instruction memory read data
//   mem_rvalid   in   read data valid (accepted only while waiting for it)
//   instr        out  instruction word to the execute stage
//   instr_valid  out  instr is valid (valid/ready handshake)
//   instr_ready  in   execute stage accepts instr
//   zero_flag    in   ALU zero flag, sampled on the handshake cycle
//   bra_result   out  branch target for the PC
//   bra_valid    out  PC loads bra_result on the next inc_pc edge
//   inc_pc       out  registered single-cycle PC advance strobe
//   busy         out  high in every state except IDLE and HALT
//   halted       out  HALT opcode retired
//
// ADDRESS_WIDTH must not exceed INSTR_WIDTH-4 (the opcode occupies the top
// four instruction bits, the target/offset field the low bits).
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int INSTR_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_rd,
    input  logic [INSTR_WIDTH-1:0]   mem_rdata,
    input  logic                     mem_rvalid,
    output logic [INSTR_WIDTH-1:0]   instr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     zero_flag,
    output logic [ADDRESS_WIDTH-1:0] bra_result,
    output logic                     bra_valid,
    output logic                     inc_pc,
    output logic                     busy,
    output logic                     halted
);

    localparam logic [3:0] OP_BRA  = 4'hC;
    localparam logic [3:0] OP_BRZ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_ISSUE    = 3'd3,
        S_SETUP    = 3'd4,
        S_PULSE    = 3'd5,
        S_HOLD     = 3'd6,
        S_HALT     = 3'd7
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                     mem_rd_q, mem_rd_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     instr_valid_q, instr_valid_d;
    logic [ADDRESS_WIDTH-1:0] bra_result_q, bra_result_d;
    logic                     bra_valid_q, bra_valid_d;
    logic                     inc_pc_q, inc_pc_d;
    logic                     busy_q, busy_d;
    logic                     halted_q, halted_d;

    logic [3:0]               opcode_s;
    logic                     taken_s;
    logic [ADDRESS_WIDTH-1:0] target_s;

    // Opcode decode and branch target of the instruction currently on offer.
    always_comb begin
        opcode_s = instr_q[INSTR_WIDTH-1 -: 4];
        case (opcode_s)
            OP_BRA:  taken_s = 1'b1;
            OP_BRZ:  taken_s = zero_flag;
            default: taken_s = 1'b0;
        endcase
`ifdef BRA_RELATIVE_EN
        // Offset is two's complement; modular addition handles the sign.
        target_s = pc + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1} + instr_q[ADDRESS_WIDTH-1:0];
`else
        target_s = instr_q[ADDRESS_WIDTH-1:0];
`endif
    end

    // Next-state and next-output computation; every output is a flop.
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = 1'b0;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        bra_result_d  = bra_result_q;
        bra_valid_d   = bra_valid_q;
        inc_pc_d      = 1'b0;
        halted_d      = halted_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d       = S_ISSUE;
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                end else begin
                    state_d       = S_WAIT_MEM;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (opcode_s == OP_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d      = S_SETUP;
                        bra_valid_d  = taken_s;
                        bra_result_d = taken_s ? target_s : {ADDRESS_WIDTH{1'b0}};
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_SETUP: begin
                state_d  = S_PULSE;
                inc_pc_d = 1'b1;
            end
            S_PULSE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // PC already advanced on the inc_pc edge, so pc is the next fetch address.
                state_d      = S_FETCH;
                mem_rd_d     = 1'b1;
                mem_addr_d   = pc;
                bra_valid_d  = 1'b0;
                bra_result_d = {ADDRESS_WIDTH{1'b0}};
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mem_addr_q    <= {ADDRESS_WIDTH{1'b0}};
            mem_rd_q      <= 1'b0;
            instr_q       <= {INSTR_WIDTH{1'b0}};
            instr_valid_q <= 1'b0;
            bra_result_q  <= {ADDRESS_WIDTH{1'b0}};
            bra_valid_q   <= 1'b0;
            inc_pc_q      <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            bra_result_q  <= bra_result_d;
            bra_valid_q   <= bra_valid_d;
            inc_pc_q      <= inc_pc_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign bra_result  = bra_result_q;
    assign bra_valid   = bra_valid_q;
    assign inc_pc      = inc_pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. The bench owns the instruction
// memory and an inc_pc-clocked PC register. A transaction-level model walks
// each instruction through its cycle timeline (fetch, memory latency, issue
// wait, setup/pulse/hold) and sets the expected output values for every
// cycle; a compare task checks all DUT outputs against them at each falling
// clock edge. Directed instructions pin the model with literal expectations,
// followed by a randomized program.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int AW = 12;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [IW-1:0] mem_rdata = 16'h0000;
    logic          mem_rvalid = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          zero_flag = 1'b0;
    logic [AW-1:0] bra_result;
    logic          bra_valid;
    logic          inc_pc;
    logic          busy;
    logic          halted;

    fetch_sequencer #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc_reg),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .zero_flag(zero_flag),
        .bra_result(bra_result), .bra_valid(bra_valid), .inc_pc(inc_pc),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // PC register: advances or loads the branch target on the inc_pc rising edge.
    always @(posedge inc_pc or posedge reset) begin
        if (reset)          pc_reg <= 12'h000;
        else if (bra_valid) pc_reg <= bra_result;
        else                pc_reg <= pc_reg + 12'h001;
    end

    logic [IW-1:0] mem [0:4095];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected outputs for the current cycle.
    logic [AW-1:0] e_addr = 12'h000;
    logic          e_rd = 1'b0;
    logic [IW-1:0] e_instr = 16'h0000;
    logic          e_iv = 1'b0;
    logic [AW-1:0] e_bres = 12'h000;
    logic          e_bv = 1'b0;
    logic          e_inc = 1'b0;
    logic          e_busy = 1'b0;
    logic          e_halt = 1'b0;
    logic [AW-1:0] e_pc = 12'h000;

    // Model state: architectural PC and the last instruction word delivered.
    logic [AW-1:0] mpc = 12'h000;
    logic [IW-1:0] last_instr = 16'h0000;
    logic [AW-1:0] obs_bres;
    logic          obs_bv;
    logic          hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        check("mem_addr",    32'(mem_addr),    32'(e_addr));
        check("mem_rd",      32'(mem_rd),      32'(e_rd));
        check("instr",       32'(instr),       32'(e_instr));
        check("instr_valid", 32'(instr_valid), 32'(e_iv));
        check("bra_result",  32'(bra_result),  32'(e_bres));
        check("bra_valid",   32'(bra_valid),   32'(e_bv));
        check("inc_pc",      32'(inc_pc),      32'(e_inc));
        check("busy",        32'(busy),        32'(e_busy));
        check("halted",      32'(halted),      32'(e_halt));
        check("pc",          32'(pc_reg),      32'(e_pc));
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Inputs that must not matter in the current cycle get random values.
    task automatic rnd_junk();
        start       = 1'($urandom_range(0, 1));
        mem_rvalid  = 1'($urandom_range(0, 1));
        mem_rdata   = 16'($urandom);
        instr_ready = 1'($urandom_range(0, 1));
        zero_flag   = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [AW-1:0] target(input logic [AW-1:0] p, input logic [IW-1:0] w);
`ifdef BRA_RELATIVE_EN
        return p + 12'h001 + w[AW-1:0];
`else
        return w[AW-1:0];
`endif
    endfunction

    task automatic zero_exp();
        e_addr = 12'h000; e_rd = 1'b0; e_instr = 16'h0000; e_iv = 1'b0;
        e_bres = 12'h000; e_bv = 1'b0; e_inc = 1'b0; e_busy = 1'b0;
        e_halt = 1'b0; e_pc = 12'h000;
        mpc = 12'h000; last_instr = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        zero_exp();
        rnd_junk();
        tick();
        tick();
        reset = 1'b0;
        rnd_junk();
        start = 1'b0;
        tick();
    endtask

    // From IDLE: one cycle with start high, then the DUT is in its fetch cycle.
    task automatic start_seq();
        rnd_junk();
        start = 1'b1;
        tick();
    endtask

    // One instruction from its fetch cycle to the next fetch cycle (or HALT).
    // zmode: 0/1 forces zero_flag at the handshake, 2 leaves it random.
    task automatic do_instr(input int lat, input int rdy, input int zmode, output logic halt_o);
        logic [IW-1:0] data;
        logic          zval;
        logic          taken;
        logic [3:0]    op;
        logic [AW-1:0] tgt;
        halt_o = 1'b0;
        zval   = 1'b0;
        rnd_junk();
        e_addr = mpc; e_rd = 1'b1; e_instr = last_instr; e_iv = 1'b0;
        e_bres = 12'h000; e_bv = 1'b0; e_inc = 1'b0; e_busy = 1'b1;
        e_halt = 1'b0; e_pc = mpc;
        tick();
        data = mem[mpc];
        e_rd = 1'b0;
        for (int i = 0; i < lat; i++) begin
            rnd_junk();
            mem_rvalid = (i == lat - 1);
            if (i == lat - 1) mem_rdata = data;
            tick();
        end
        last_instr = data;
        e_iv = 1'b1;
        e_instr = data;
        for (int j = 0; j <= rdy; j++) begin
            rnd_junk();
            instr_ready = (j == rdy);
            if (j == rdy && zmode < 2) zero_flag = 1'(zmode);
            zval = zero_flag;
            tick();
        end
        e_iv = 1'b0;
        op = data[15:12];
        if (op == 4'hF) begin
            e_halt = 1'b1;
            e_busy = 1'b0;
            halt_o = 1'b1;
            return;
        end
        taken = (op == 4'hC) || ((op == 4'hD) && zval);
        tgt = target(mpc, data);
        e_bv = taken;
        e_bres = taken ? tgt : 12'h000;
        rnd_junk();
        tick();
        mpc = taken ? tgt : mpc + 12'h001;
        e_pc = mpc;
        e_inc = 1'b1;
        obs_bres = bra_result;
        obs_bv = bra_valid;
        rnd_junk();
        tick();
        e_inc = 1'b0;
        rnd_junk();
        tick();
    endtask

    task automatic halt_phase(input int n);
        for (int k = 0; k < n; k++) begin
            rnd_junk();
            start = (k % 2 == 0);
            tick();
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        do_reset();

`ifndef BRA_RELATIVE_EN
        mem[0] = 16'h1000; mem[1] = 16'hC123; mem[12'h123] = 16'hD050;
        mem[12'h124] = 16'hD050; mem[12'h050] = 16'h2AAA;
        mem[12'h051] = 16'hCFFF; mem[12'hFFF] = 16'h1111;
        start_seq();
        check("first_fetch_addr", 32'(mem_addr), 32'h000);
        do_instr(1, 0, 2, hit);
        check("next_addr_plain", 32'(mem_addr), 32'h001);
        check("instr_plain", 32'(instr), 32'h1000);
        do_instr(1, 0, 2, hit);
        check("bra_result_bra", 32'(obs_bres), 32'h123);
        check("bra_valid_bra", 32'(obs_bv), 32'h1);
        check("next_addr_bra", 32'(mem_addr), 32'h123);
        check("bra_valid_cleared", 32'(bra_valid), 32'h0);
        do_instr(2, 1, 0, hit);
        check("brz_not_taken_addr", 32'(mem_addr), 32'h124);
        do_instr(1, 0, 1, hit);
        check("brz_taken_result", 32'(obs_bres), 32'h050);
        check("brz_taken_addr", 32'(mem_addr), 32'h050);
        do_instr(1, 5, 2, hit);
        check("ready_stall_addr", 32'(mem_addr), 32'h051);
        do_instr(3, 0, 2, hit);
        check("bra_top_addr", 32'(mem_addr), 32'hFFF);
        mem[0] = 16'hF000;
        do_instr(1, 0, 2, hit);
        check("wrap_addr", 32'(mem_addr), 32'h000);
        do_instr(1, 0, 2, hit);
`else
        mem[0] = 16'hC00F; mem[12'h010] = 16'hCFFE; mem[12'h00F] = 16'hF000;
        start_seq();
        do_instr(1, 0, 2, hit);
        check("rel_fwd_addr", 32'(mem_addr), 32'h010);
        do_instr(2, 1, 2, hit);
        check("rel_back_result", 32'(obs_bres), 32'h00F);
        check("rel_back_addr", 32'(mem_addr), 32'h00F);
        do_instr(1, 0, 2, hit);
`endif
        halt_phase(6);
        check("halted_set", 32'(halted), 32'h1);
        check("busy_in_halt", 32'(busy), 32'h0);
        do_reset();
        check("halted_after_reset", 32'(halted), 32'h0);

        // Reset while waiting for memory; late read data must be dropped.
        start_seq();
        rnd_junk();
        e_addr = 12'h000; e_rd = 1'b1; e_busy = 1'b1;
        tick();
        rnd_junk();
        mem_rvalid = 1'b0;
        e_rd = 1'b0;
        tick();
        reset = 1'b1;
        zero_exp();
        rnd_junk();
        mem_rvalid = 1'b0;
        start = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rnd_junk();
            start = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = 16'hC777;
            tick();
        end
        check("late_rvalid_instr", 32'(instr), 32'h0000);
        check("late_rvalid_busy", 32'(busy), 32'h0);

        // Randomized program without HALT, then a HALT to finish.
        for (int a = 0; a < 4096; a++)
            mem[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
        start_seq();
        for (int k = 0; k < 150; k++)
            do_instr($urandom_range(1, 3), $urandom_range(0, 3), 2, hit);
        mem[mpc] = 16'hF000;
        do_instr(1, 1, 2, hit);
        halt_phase(3);
        check("final_halted", 32'(halted), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch/sequencing controller that drives the program counter's branch and advance interface.
- Reads the current PC and fetches the instruction word from instruction memory.
- Hands the instruction to the execute stage over a valid/ready handshake.
- Resolves branches, then drives bra_result/bra_valid and a clean single-cycle inc_pc pulse. The PC register clocks on the rising edge of inc_pc.

Parameters:
- ADDRESS_WIDTH, 12, PC/memory address width; must be ≤ INSTR_WIDTH-4.
- INSTR_WIDTH, 16, instruction word width; opcode = instr[INSTR_WIDTH-1 -: 4].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; same reset that clears the PC.
- start  input  1  begin sequencing from IDLE; level-sampled.
- pc  input  ADDRESS_WIDTH  current PC value.
- mem_addr  output  ADDRESS_WIDTH  instruction memory read address.
- mem_rd  output  1  one-cycle read strobe.
- mem_rdata  input  INSTR_WIDTH  read data.
- mem_rvalid  input  1  read data valid; earliest is the cycle after mem_rd.
- instr  output  INSTR_WIDTH  instruction to execute stage.
- instr_valid  output  1  instr is valid.
- instr_ready  input  1  execute stage accepts.
- zero_flag  input  1  ALU zero flag; sampled on the instr handshake cycle.
- bra_result  output  ADDRESS_WIDTH  branch target to PC.
- bra_valid  output  1  load bra_result on next inc_pc edge.
- inc_pc  output  1  PC advance strobe; registered, glitch-free.
- busy  output  1  high in any state except IDLE and HALT.
- halted  output  1  HALT opcode retired.

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including instr, mem_addr and bra_result.
- IDLE: start=1 -> FETCH.
- FETCH (1 cycle): mem_rd=1, mem_addr=pc -> WAIT_MEM.
- WAIT_MEM: mem_addr held. On mem_rvalid, capture mem_rdata into instr -> ISSUE. mem_rvalid in any other state is ignored.
- ISSUE: instr_valid=1 with instr held stable until instr_ready. The handshake cycle is instr_valid & instr_ready. On the handshake, decode the opcode:
  - 4'hF HALT -> HALT. No inc_pc.
  - 4'hC BRA -> taken.
  - 4'hD BRZ -> taken if zero_flag=1.
  - Any other opcode -> not taken.
- Branch outputs: registered on the handshake edge.
  - Taken: bra_valid=1, bra_result=instr[ADDRESS_WIDTH-1:0].
  - Not taken: bra_valid=0, bra_result=0.
  - instr_valid drops on the same edge.
- SETUP (1 cycle): bra_* stable, inc_pc=0 -> PULSE.
- PULSE (1 cycle): inc_pc=1 -> HOLD.
- HOLD (1 cycle): inc_pc=0, bra_* still held. On exit, bra_valid and bra_result clear to 0 -> FETCH.
- Setup/hold guarantee: bra_* are stable ≥1 clk before the inc_pc rising edge and ≥1 clk after its falling edge.
- Minimum instruction period: 6 clks (FETCH, WAIT_MEM 1, ISSUE 1, SETUP, PULSE, HOLD).
- HALT: halted=1, busy=0. start is ignored. Exit only via reset.
- start is ignored when not in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A pending mem_rvalid arriving after reset deasserts is ignored.
- Wrap-around: PC 2^ADDRESS_WIDTH-1 advances to 0; this is the PC's natural wrap and needs no special handling here.

Optional Feature:
BRA_RELATIVE_EN
- Defined: taken-branch target = (pc + 1 + instr[ADDRESS_WIDTH-1:0]) mod 2^ADDRESS_WIDTH. The offset field is two's complement, and pc is sampled on the handshake cycle.
- Undefined: target is absolute, bra_result = instr[ADDRESS_WIDTH-1:0].

Test Plan:
- Reset, start; pc=0; mem returns 0x1000 one cycle after mem_rd; instr_ready=1 -> mem_addr=0; instr=0x1000; bra_valid=0; inc_pc high for exactly 1 clk, 2 clks after the handshake; next mem_addr=1.
- Fetch 0xC123 -> bra_valid=1 and bra_result=0x123 from the cycle before inc_pc rises through the cycle after it falls; next fetch at 0x123; bra_* then 0.
- 0xD050 with zero_flag=0 -> bra_valid=0, next fetch pc+1. Repeat with zero_flag=1 -> bra_result=0x050, bra_valid=1.
- instr_ready held low 5 clks in ISSUE -> instr_valid=1 and instr constant throughout; no inc_pc; one pulse after ready rises.
- Fetch 0xF000 -> halted=1, busy=0, no inc_pc; start pulses ignored; reset -> halted=0, IDLE.
- Reset asserted in WAIT_MEM; mem_rvalid arrives after reset release -> all outputs 0, state IDLE, data ignored. With BRA_RELATIVE_EN, pc=0x010 and instr 0xCFFE -> bra_result=0x00F.
